// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle RV32I control sequencer owning the shared RAM port
module cpu_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       nReset,
  input  logic [6:0] opcode,
  input  logic       regw_dec,
  input  logic       incr_dec,
  input  logic       ramR_dec,
  input  logic       ramW_dec,
  input  logic       memAck,
  output logic       memReq,
  output logic       memSel,
  output logic       memWe,
  output logic       irLoad,
  output logic       mdrLoad,
  output logic       regWen,
  output logic       pcEn,
  output logic       retired,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic          illegal_q, timeout_q;
  logic          set_illegal, set_timeout;
  logic          legal_op, waiting, expired, store;

  always_comb begin
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b0100011, 7'b0110111, 7'b0010111: legal_op = 1'b1;
      default:                            legal_op = 1'b0;
    endcase
  end

  assign waiting = (cur == S_FETCH) || (cur == S_MEM);
  assign expired = waiting && !memAck && (wait_cnt == CW'(TIMEOUT));
  // A simultaneous read+write request is resolved as a store.
  assign store   = ramW_dec;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      cur       <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cur       <= nxt;
      wait_cnt  <= wait_nxt;
      illegal_q <= illegal_q | set_illegal;
      timeout_q <= timeout_q | set_timeout;
    end
  end

  always_comb begin
    nxt         = cur;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (cur)
      S_FETCH: begin
        if (memAck) begin
          nxt = S_DECODE;
        end else if (expired) begin
          nxt         = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        if (legal_op) begin
          nxt = S_EXECUTE;
        end else begin
          nxt         = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_EXECUTE:   nxt = (ramR_dec || ramW_dec) ? S_MEM : S_WRITEBACK;
      S_MEM: begin
        if (memAck) begin
          nxt = S_WRITEBACK;
        end else if (expired) begin
          nxt         = S_HALT;
          set_timeout = 1'b1;
        end
      end
      S_WRITEBACK: nxt = S_FETCH;
      S_HALT:      nxt = S_HALT;
      default:     nxt = S_HALT;
    endcase
  end

  // Every entry into FETCH or MEM comes from a different state, so a state change clears the count.
  always_comb begin
    wait_nxt = wait_cnt;
    if (nxt != cur) begin
      wait_nxt = '0;
    end else if (waiting && !memAck) begin
      wait_nxt = wait_cnt + 1'b1;
    end
  end

  // Outputs are gated by nReset so an asserted reset drops them without waiting for a clock edge.
  always_comb begin
    memReq  = 1'b0;
    memSel  = 1'b0;
    memWe   = 1'b0;
    irLoad  = 1'b0;
    mdrLoad = 1'b0;
    regWen  = 1'b0;
    pcEn    = 1'b0;
    retired = 1'b0;
    if (nReset) begin
      case (cur)
        S_FETCH: begin
          memReq = 1'b1;
          irLoad = memAck;
        end
        S_MEM: begin
          memReq  = 1'b1;
          memSel  = 1'b1;
          memWe   = store;
          mdrLoad = memAck && ramR_dec && !store;
        end
        S_WRITEBACK: begin
          regWen  = regw_dec;
          pcEn    = incr_dec;
          retired = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = cur;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  logic       clock = 1'b0;
  logic       nReset = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic       regw_dec = 1'b0, incr_dec = 1'b0, ramR_dec = 1'b0, ramW_dec = 1'b0;
  logic       memAck = 1'b0;
  logic       memReq, memSel, memWe, irLoad, mdrLoad, regWen, pcEn, retired;
  logic [2:0] state;
  logic       illegal, timeout;

  cpu_sequencer #(.TIMEOUT(255)) dut (
    .clock(clock), .nReset(nReset), .opcode(opcode),
    .regw_dec(regw_dec), .incr_dec(incr_dec), .ramR_dec(ramR_dec), .ramW_dec(ramW_dec),
    .memAck(memAck), .memReq(memReq), .memSel(memSel), .memWe(memWe),
    .irLoad(irLoad), .mdrLoad(mdrLoad), .regWen(regWen), .pcEn(pcEn),
    .retired(retired), .state(state), .illegal(illegal), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_valid = 1'b0;
  logic [12:0] exp_vec = '0;
  logic [12:0] act_vec;
  logic        m_illegal = 1'b0;
  logic        m_timeout = 1'b0;
  int          since_ret = 0;
  int          last_gap = 0;

  assign act_vec = {state, memReq, memSel, memWe, irLoad, mdrLoad, regWen, pcEn, retired, illegal, timeout};

  always @(negedge clock) begin
    if (exp_valid) begin
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got=%b expected=%b (state,req,sel,we,ir,mdr,regw,pc,ret,ill,to)",
                 $time, act_vec, exp_vec);
      end
    end
    if (!nReset) since_ret = 0;
    else if (retired) begin
      last_gap  = since_ret + 1;
      since_ret = 0;
    end else since_ret++;
  end

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
           op == 7'b0100011 || op == 7'b0110111 || op == 7'b0010111;
  endfunction

  // ctl = {memReq, memSel, memWe, irLoad, mdrLoad, regWen, pcEn, retired} expected for this cycle
  task automatic step(input logic ack, input logic [2:0] st, input logic [7:0] ctl);
    memAck    = ack;
    exp_vec   = {st, ctl, m_illegal, m_timeout};
    exp_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    nReset    = 1'b0;
    memAck    = rbit();
    m_illegal = 1'b0;
    m_timeout = 1'b0;
    exp_vec   = '0;
    exp_valid = 1'b1;
    #1;
    chk("reset_memReq", int'(memReq), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_flags", int'({illegal, timeout}), 0);
    repeat (2) @(posedge clock);
    #1;
    nReset = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic rg, input logic inc,
                           input logic rr, input logic rw, input int df, input int dm,
                           input bit abort);
    opcode   = op;
    regw_dec = rg;
    incr_dec = inc;
    ramR_dec = rr;
    ramW_dec = rw;
    repeat (df) step(1'b0, 3'd0, 8'b1000_0000);
    step(1'b1, 3'd0, 8'b1001_0000);
    step(rbit(), 3'd1, 8'h00);
    if (!is_legal(op)) begin
      m_illegal = 1'b1;
      repeat (20) step(rbit(), 3'd5, 8'h00);
      return;
    end
    step(rbit(), 3'd2, 8'h00);
    if (rr || rw) begin
      if (abort) begin
        memAck = 1'b0;
        #2;
        do_reset();
        return;
      end
      repeat (dm) step(1'b0, 3'd3, {2'b11, rw, 5'b0});
      step(1'b1, 3'd3, {2'b11, rw, 1'b0, rr & ~rw, 3'b000});
    end
    step(rbit(), 3'd4, {5'b0, rg, inc, 1'b1});
  endtask

  logic [6:0] legal_ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                7'b0100011, 7'b0110111, 7'b0010111};

  initial begin
    logic [6:0] op;
    logic       rr, rw;
    int         n, mode;

    do_reset();
    run_instr(7'b0110011, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("alu_gap_first", last_gap, 4);
    run_instr(7'b0110011, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("alu_gap", last_gap, 4);
    run_instr(7'b0000011, 1'b1, 1'b1, 1'b1, 1'b0, 0, 3, 1'b0);
    chk("load_delay3_gap", last_gap, 8);
    run_instr(7'b0000011, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("load_gap", last_gap, 5);
    run_instr(7'b0100011, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    chk("store_gap", last_gap, 5);
    run_instr(7'b0010011, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0);
    chk("fetch_delay2_gap", last_gap, 6);
    run_instr(7'b0000011, 1'b1, 1'b1, 1'b1, 1'b1, 1, 2, 1'b0);
    run_instr(7'b1111111, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("illegal_flag", int'(illegal), 1);
    chk("illegal_state", int'(state), 5);

    do_reset();
    repeat (256) step(1'b0, 3'd0, 8'b1000_0000);
    m_timeout = 1'b1;
    repeat (5) step(rbit(), 3'd5, 8'h00);
    chk("timeout_flag", int'(timeout), 1);
    chk("timeout_state", int'(state), 5);

    for (int s = 0; s < 10; s++) begin
      do_reset();
      n = $urandom_range(4, 10);
      for (int i = 0; i < n; i++) begin
        op = legal_ops[$urandom_range(0, 5)];
        run_instr(op, rbit(), rbit(), rbit(), rbit(),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        do op = 7'($urandom); while (is_legal(op));
        run_instr(op, rbit(), rbit(), rbit(), rbit(), $urandom_range(0, 2), 0, 1'b0);
      end else if (mode == 1) begin
        rr = rbit();
        rw = rr ? rbit() : 1'b1;
        run_instr(7'b0000011, rbit(), rbit(), rr, rw, $urandom_range(0, 2), 0, 1'b1);
        run_instr(7'b0110111, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("post_abort_gap", last_gap, 4);
      end
    end

    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and gates the decoder's static control outputs into per-cycle enables. It also owns the single shared RAM port, switching it between instruction fetch (address = PC) and data access (address = ALU result). This gives loads and stores the extra cycles they need.

## Interface
- TIMEOUT, default 255: max cycles to wait for memAck in a memory state before halting; counter width $clog2(TIMEOUT+1).

Ports:
- clock  in  1  system clock, rising edge
- nReset  in  1  asynchronous, active-low reset
- opcode  in  7  opcode field of the instruction register
- regw_dec  in  1  decoder register-write request
- incr_dec  in  1  decoder PC-increment request
- ramR_dec  in  1  decoder RAM-read request
- ramW_dec  in  1  decoder RAM-write request
- memAck  in  1  RAM completes current access this cycle
- memReq  out  1  RAM access request
- memSel  out  1  RAM address mux: 0 = PC (fetch), 1 = ALU result (data)
- memWe  out  1  RAM write enable
- irLoad  out  1  load instruction register
- mdrLoad  out  1  load memory data register
- regWen  out  1  register file write enable
- pcEn  out  1  PC update enable
- retired  out  1  one-cycle pulse per completed instruction
- state  out  3  current state encoding
- illegal  out  1  sticky: unsupported opcode decoded
- timeout  out  1  sticky: memAck not received within TIMEOUT cycles

## Operation
- States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5. Codes 6 and 7 go to HALT next cycle.
- All outputs are Moore, decoded from state and registered flags, except irLoad and mdrLoad, which are qualified by memAck.
- FETCH: memReq=1, memSel=0, memWe=0. Stay until memAck=1. On the ack cycle, irLoad=1, then go to DECODE.
- DECODE: one cycle. Legal opcodes are 0110011 (R-ALU), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 0110111 (lui) and 0010111 (auipc). Any other opcode sets illegal and goes to HALT. Otherwise go to EXECUTE.
- EXECUTE: one cycle. Go to MEM if ramR_dec or ramW_dec, otherwise go to WRITEBACK.
- MEM: memReq=1, memSel=1, memWe=ramW_dec. Stay until memAck. On the ack cycle, mdrLoad=ramR_dec, then go to WRITEBACK.
- If ramR_dec and ramW_dec are both 1, treat the access as a store: memWe=1 and mdrLoad=0.
- WRITEBACK: regWen=regw_dec, pcEn=incr_dec, retired=1. Then go to FETCH.
- HALT: all enables and requests are 0. illegal and timeout hold. Only reset exits HALT.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle in those states without memAck.
  - When the counter equals TIMEOUT and memAck=0: set timeout and go to HALT. No irLoad or mdrLoad is issued.
- memAck outside FETCH and MEM is ignored.
- memReq, memSel and memWe stay stable from request until the ack cycle inclusive.

## Timing
- nReset low: state=FETCH, counter=0, illegal=0, timeout=0, and every output is forced to 0 (including memReq).
- After reset release, memReq=1 in the first cycle.
- Reset asserted mid-access drops memReq immediately, without waiting for ack.
- With a zero-wait RAM (memAck in the same cycle as memReq):
  - ALU, lui and auipc instructions take 4 cycles.
  - Loads and stores take 5 cycles.
- Each cycle of memAck delay adds one cycle.
- retired is asserted exactly once per non-halting instruction.
- State is registered. Transitions take effect on the rising clock edge after their condition is sampled.

## Test plan
- Reset release, opcode=0110011, regw_dec=1, incr_dec=1, memAck tied 1 -> state sequence 0,1,2,4,0. irLoad in cycle 1, regWen and pcEn in cycle 4, retired every 4 cycles.
- Load (0000011, ramR_dec=1), memAck delayed 3 cycles in MEM -> memReq=1 and memSel=1 held for 4 cycles. mdrLoad pulses on the ack cycle only, then WRITEBACK with regWen=1.
- Store (0100011, ramW_dec=1, regw_dec=0) -> memWe=1 during MEM. regWen=0 and pcEn=1 in WRITEBACK.
- Opcode 1111111 in DECODE -> illegal=1, state=5. All enables stay 0 for 20 cycles, and memAck pulses have no effect.
- memAck held 0 in FETCH with TIMEOUT=255 -> timeout=1 and state=5 after 256 cycles. No irLoad.
- nReset pulsed low mid-MEM -> memReq=0 asynchronously and flags cleared. The first cycle after release is FETCH with memReq=1.
